// File: rtl/pulse_capture_pkg.sv
// Shared types and constants for the input-capture unit.
package pulse_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ACTIVE,
        INACTIVE
    } state_t;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input, with registered one-cycle
// rise/fall pulses. Pulses appear STAGES+1 clocks after the input changes.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
            rise <= sync[STAGES-1] & ~prev;
            fall <= ~sync[STAGES-1] & prev;
        end
    end

endmodule

// File: rtl/pulse_capture.sv
// Input-capture unit: measures period and active-phase length of a synchronised
// input and hands results to a consumer over valid/ready, with sticky error flags.
module pulse_capture
    import pulse_capture_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    input  logic             edge_sel,
    input  logic [WIDTH-1:0] max_period,
    input  logic             clr,
    output logic             cap_valid,
    input  logic             cap_ready,
    output logic [WIDTH-1:0] cap_period,
    output logic [WIDTH-1:0] cap_active,
    output logic             overrun,
    output logic             timeout
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] act_len;
    logic             act_load;
    logic             capture;
    logic             timeout_set;
    logic             overrun_set;
    logic             timeout_hit;
    logic             rise;
    logic             fall;
    logic             ref_edge;
    logic             opp_edge;
    logic             en_q;
    logic             edge_q;

    sync_edge_detect #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sig_in),
        .rise (rise),
        .fall (fall)
    );

    assign ref_edge    = (edge_q == EDGE_FALLING) ? fall : rise;
    assign opp_edge    = (edge_q == EDGE_FALLING) ? rise : fall;
    assign cnt_inc     = (cnt == '1) ? cnt : cnt + WIDTH'(1);
    assign timeout_hit = (max_period != '0) && (cnt == max_period);

    // Edge polarity is latched only on the enable rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            edge_q <= EDGE_RISING;
        end else begin
            en_q <= en;
            if (en && !en_q) begin
                edge_q <= edge_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:     state_next = ARMED;
                ARMED:    if (ref_edge) state_next = ACTIVE;
                ACTIVE: begin
                    if (timeout_hit)   state_next = ARMED;
                    else if (opp_edge) state_next = INACTIVE;
                end
                INACTIVE: begin
                    if (timeout_hit)   state_next = ARMED;
                    else if (ref_edge) state_next = ACTIVE;
                end
                default:  state_next = IDLE;
            endcase
        end
    end

    // A reference edge seen while ACTIVE only restarts the count; no capture.
    always_comb begin
        cnt_next    = cnt;
        act_load    = 1'b0;
        capture     = 1'b0;
        timeout_set = 1'b0;
        if (!en) begin
            cnt_next = '0;
        end else begin
            case (state)
                ARMED: if (ref_edge) cnt_next = WIDTH'(1);
                ACTIVE: begin
                    if (timeout_hit) begin
                        timeout_set = 1'b1;
                        cnt_next    = '0;
                    end else if (ref_edge) begin
                        cnt_next = WIDTH'(1);
                    end else begin
                        cnt_next = cnt_inc;
                        act_load = opp_edge;
                    end
                end
                INACTIVE: begin
                    if (timeout_hit) begin
                        timeout_set = 1'b1;
                        cnt_next    = '0;
                    end else if (ref_edge) begin
                        capture  = 1'b1;
                        cnt_next = WIDTH'(1);
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                default: cnt_next = cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            act_len <= '0;
        end else begin
            cnt <= cnt_next;
            if (act_load) begin
                act_len <= cnt;
            end
        end
    end

    // A new result may replace the held one only when it is being taken this cycle.
    assign overrun_set = capture && cap_valid && !cap_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid  <= 1'b0;
            cap_period <= '0;
            cap_active <= '0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            if (capture && (!cap_valid || cap_ready)) begin
                cap_valid  <= 1'b1;
                cap_period <= cnt;
                cap_active <= act_len;
            end else if (cap_valid && cap_ready) begin
                cap_valid <= 1'b0;
            end
            overrun <= overrun_set | (overrun & ~clr);
            timeout <= timeout_set | (timeout & ~clr);
        end
    end

endmodule

// File: tb/tb_pulse_capture.sv
// Directed, table-driven bench for pulse_capture (8-bit counter build).
module tb_pulse_capture;
    import pulse_capture_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         sig_in;
    logic         edge_sel;
    logic [W-1:0] max_period;
    logic         clr;
    logic         cap_valid;
    logic         cap_ready;
    logic [W-1:0] cap_period;
    logic [W-1:0] cap_active;
    logic         overrun;
    logic         timeout;

    int n_cmp;
    int n_bad;

    logic [W-1:0] q_period[$];
    logic [W-1:0] q_active[$];

    typedef struct {
        logic edge_sel;
        int   hi;
        int   lo;
        int   exp_period;
        int   exp_active;
    } vec_t;

    vec_t vecs[6];

    pulse_capture #(
        .WIDTH      (W),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sig_in    (sig_in),
        .edge_sel  (edge_sel),
        .max_period(max_period),
        .clr       (clr),
        .cap_valid (cap_valid),
        .cap_ready (cap_ready),
        .cap_period(cap_period),
        .cap_active(cap_active),
        .overrun   (overrun),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Logs every accepted result, sampled between input updates and the next edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (cap_valid && cap_ready) begin
                q_period.push_back(cap_period);
                q_active.push_back(cap_active);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic drive_wave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            sig_in = 1'b1;
            repeat (hi) @(negedge clk);
            sig_in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic restart(input logic es);
        en = 1'b0;
        repeat (2) @(negedge clk);
        edge_sel = es;
        en       = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v, output int base);
        restart(v.edge_sel);
        base = q_period.size();
        drive_wave(v.hi, v.lo, 4);
        repeat (8) @(negedge clk);
    endtask

    task automatic check_log(input string name, input int base, input int count, input int ep, input int ea);
        checkOutput({name, "_count"}, 32'(q_period.size() - base), 32'(count));
        for (int k = base; k < q_period.size(); k++) begin
            checkOutput({name, "_period"}, 32'(q_period[k]), 32'(ep));
            checkOutput({name, "_active"}, 32'(q_active[k]), 32'(ea));
        end
    endtask

    initial begin
        int base;
        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{1'b0, 3, 5, 8, 3};
        vecs[1] = '{1'b1, 3, 5, 8, 5};
        vecs[2] = '{1'b0, 2, 6, 8, 2};
        vecs[3] = '{1'b1, 4, 7, 11, 7};
        vecs[4] = '{1'b0, 1, 1, 2, 1};
        vecs[5] = '{1'b0, 10, 20, 30, 10};

        rst_n      = 1'b0;
        en         = 1'b0;
        sig_in     = 1'b0;
        edge_sel   = EDGE_RISING;
        max_period = '0;
        clr        = 1'b0;
        cap_ready  = 1'b1;
        repeat (3) @(negedge clk);

        checkOutput("rst_valid", 32'(cap_valid), 0);
        checkOutput("rst_period", 32'(cap_period), 0);
        checkOutput("rst_active", 32'(cap_active), 0);
        checkOutput("rst_overrun", 32'(overrun), 0);
        checkOutput("rst_timeout", 32'(timeout), 0);
        checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] table-driven periodic vectors");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], base);
            check_log($sformatf("vec%0d", i), base, 3, vecs[i].exp_period, vecs[i].exp_active);
        end
        checkOutput("vec_overrun", 32'(overrun), 0);

        $display("[TB] startup latency");
        restart(EDGE_RISING);
        drive_wave(3, 5, 1);
        checkOutput("start_no_first", 32'(cap_valid), 0);
        sig_in = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("start_valid_c%0d", k), 32'(cap_valid), (k == 4) ? 1 : 0);
        end
        checkOutput("start_period", 32'(cap_period), 8);
        checkOutput("start_active", 32'(cap_active), 3);
        sig_in = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] backpressure");
        cap_ready = 1'b0;
        restart(EDGE_RISING);
        base = q_period.size();
        drive_wave(3, 5, 1);
        drive_wave(2, 8, 1);
        sig_in = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("bp_valid", 32'(cap_valid), 1);
        checkOutput("bp_period", 32'(cap_period), 8);
        checkOutput("bp_active", 32'(cap_active), 3);
        checkOutput("bp_overrun", 32'(overrun), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("bp_clr", 32'(overrun), 0);
        cap_ready = 1'b1;
        @(negedge clk);
        cap_ready = 1'b0;
        checkOutput("bp_drained", 32'(cap_valid), 0);
        check_log("bp_xfer", base, 1, 8, 3);

        $display("[TB] transfer collision");
        sig_in = 1'b0;
        restart(EDGE_RISING);
        base = q_period.size();
        drive_wave(3, 5, 1);
        drive_wave(2, 8, 1);
        sig_in = 1'b1;
        repeat (3) @(negedge clk);
        cap_ready = 1'b1;
        @(negedge clk);
        cap_ready = 1'b0;
        checkOutput("col_valid", 32'(cap_valid), 1);
        checkOutput("col_period", 32'(cap_period), 10);
        checkOutput("col_active", 32'(cap_active), 2);
        checkOutput("col_overrun", 32'(overrun), 0);
        check_log("col_xfer", base, 1, 8, 3);

        $display("[TB] timeout");
        sig_in    = 1'b0;
        cap_ready = 1'b1;
        max_period = 8'd20;
        restart(EDGE_RISING);
        base = q_period.size();
        sig_in = 1'b1;
        repeat (3) @(negedge clk);
        sig_in = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("to_before", 32'(timeout), 0);
        @(negedge clk);
        checkOutput("to_set", 32'(timeout), 1);
        checkOutput("to_state", 32'(dut.state), 32'(ARMED));
        checkOutput("to_no_valid", 32'(cap_valid), 0);
        checkOutput("to_no_xfer", 32'(q_period.size() - base), 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("to_clr", 32'(timeout), 0);

        $display("[TB] saturation with timeout disabled");
        max_period = '0;
        restart(EDGE_RISING);
        base = q_period.size();
        sig_in = 1'b1;
        repeat (3) @(negedge clk);
        sig_in = 1'b0;
        repeat (300) @(negedge clk);
        checkOutput("sat_cnt", 32'(dut.cnt), 255);
        checkOutput("sat_no_timeout", 32'(timeout), 0);
        sig_in = 1'b1;
        repeat (6) @(negedge clk);
        sig_in = 1'b0;
        repeat (4) @(negedge clk);
        check_log("sat_cap", base, 1, 255, 3);

        $display("[TB] enable dropped mid-ACTIVE");
        restart(EDGE_RISING);
        base = q_period.size();
        sig_in = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("dis_active", 32'(dut.state), 32'(ACTIVE));
        en = 1'b0;
        repeat (4) @(negedge clk);
        en     = 1'b1;
        sig_in = 1'b0;
        repeat (5) @(negedge clk);
        drive_wave(3, 5, 3);
        repeat (8) @(negedge clk);
        check_log("dis_cap", base, 2, 8, 3);

        $display("[TB] reset mid-INACTIVE");
        cap_ready = 1'b0;
        restart(EDGE_RISING);
        drive_wave(3, 5, 2);
        checkOutput("rmid_pre_valid", 32'(cap_valid), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rmid_valid", 32'(cap_valid), 0);
        checkOutput("rmid_period", 32'(cap_period), 0);
        checkOutput("rmid_active", 32'(cap_active), 0);
        checkOutput("rmid_overrun", 32'(overrun), 0);
        checkOutput("rmid_timeout", 32'(timeout), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        cap_ready = 1'b1;
        @(negedge clk);
        base = q_period.size();
        drive_wave(3, 5, 3);
        repeat (8) @(negedge clk);
        check_log("rmid_resume", base, 2, 8, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
